// File: rtl/router_fsm.sv
// Control FSM for the 3-port packet router: sequences header, payload, parity and FIFO-full stalls.
// Latency: header written 1 cycle after decode, payload 1 byte/cycle, one parity-check cycle per packet.
// Backpressure: busy is high in every state except DECODE_ADDRESS and LOAD_DATA; the source holds its byte while busy.
//
// Ports:
//   clock, resetn                    rising-edge clock, synchronous active-low reset
//   pkt_valid, data_in[1:0]          source handshake and low bits of the current byte (address in decode)
//   fifo_full                        full flag of the currently addressed output FIFO
//   fifo_empty_0..2, soft_reset_0..2 per-output-FIFO empty flags and read-timeout resets
//   parity_done, low_packet_valid    status from the register/parity stage
//   detect_add .. rst_int_reg        one-hot state strobes to the register/parity stage
//   write_enb_reg, busy              FIFO write enable and source flow control
module router_fsm (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_packet_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [1:0] addr_reg;

    // Address on the header byte; 2'b11 names no port and the packet is dropped.
    logic       hdr_valid;
    logic       empty_at_hdr;   // empty flag of the port named by the incoming header
    logic       empty_at_addr;  // empty flag of the latched destination
    logic       soft_at_addr;   // timeout reset of the latched destination

    assign hdr_valid = pkt_valid && (data_in != 2'b11);

    always_comb begin
        empty_at_hdr = 1'b0;
        case (data_in)
            2'd0:    empty_at_hdr = fifo_empty_0;
            2'd1:    empty_at_hdr = fifo_empty_1;
            2'd2:    empty_at_hdr = fifo_empty_2;
            default: empty_at_hdr = 1'b0;
        endcase
    end

    always_comb begin
        empty_at_addr = 1'b0;
        soft_at_addr  = 1'b0;
        case (addr_reg)
            2'd0: begin
                empty_at_addr = fifo_empty_0;
                soft_at_addr  = soft_reset_0;
            end
            2'd1: begin
                empty_at_addr = fifo_empty_1;
                soft_at_addr  = soft_reset_1;
            end
            2'd2: begin
                empty_at_addr = fifo_empty_2;
                soft_at_addr  = soft_reset_2;
            end
            default: begin
                empty_at_addr = 1'b0;
                soft_at_addr  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= DECODE_ADDRESS;
            addr_reg <= 2'd0;
        end else begin
            state <= next_state;
            if (state == DECODE_ADDRESS && hdr_valid) begin
                addr_reg <= data_in;
            end
        end
    end

    always_comb begin
        next_state = DECODE_ADDRESS;
        case (state)
            DECODE_ADDRESS: begin
                if (hdr_valid) begin
                    next_state = empty_at_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end else begin
                    next_state = DECODE_ADDRESS;
                end
            end
            LOAD_FIRST_DATA:    next_state = LOAD_DATA;
            LOAD_DATA: begin
                // A full FIFO takes priority over the end of the payload so the
                // parity byte is never written into a full FIFO.
                if (fifo_full)       next_state = FIFO_FULL_STATE;
                else if (!pkt_valid) next_state = LOAD_PARITY;
                else                 next_state = LOAD_DATA;
            end
            FIFO_FULL_STATE:    next_state = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: begin
                if (parity_done)           next_state = DECODE_ADDRESS;
                else if (low_packet_valid) next_state = LOAD_PARITY;
                else                       next_state = LOAD_DATA;
            end
            LOAD_PARITY:        next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY:    next_state = empty_at_addr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            default:            next_state = DECODE_ADDRESS;
        endcase

        // A read timeout on the destination port abandons the packet. Only the
        // latched port matters; in decode the latch is stale, so it is ignored there.
        if (state != DECODE_ADDRESS && soft_at_addr) begin
            next_state = DECODE_ADDRESS;
        end
    end

    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        rst_int_reg   = 1'b0;
        write_enb_reg = 1'b0;
        busy          = 1'b1;
        case (state)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
                busy       = 1'b0;
            end
            LOAD_FIRST_DATA: begin
                lfd_state     = 1'b1;
                write_enb_reg = 1'b1;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b0;
            end
            FIFO_FULL_STATE:    full_state = 1'b1;
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
            end
            LOAD_PARITY:        write_enb_reg = 1'b1;
            CHECK_PARITY_ERROR: rst_int_reg = 1'b1;
            WAIT_TILL_EMPTY:    busy = 1'b1;
            default:            busy = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: walks packets through every state and checks the Moore outputs.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Expected output vectors are hand-derived per state.
module tb_router_fsm;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_packet_valid;
    logic       detect_add, lfd_state, ld_state, laf_state;
    logic       full_state, rst_int_reg, write_enb_reg, busy;

    int total = 0;
    int bad   = 0;

    // {detect_add, lfd, ld, laf, full, rst_int_reg, write_enb_reg, busy}
    localparam logic [7:0] O_DA   = 8'b1000_0000;
    localparam logic [7:0] O_LFD  = 8'b0100_0011;
    localparam logic [7:0] O_LD   = 8'b0010_0010;
    localparam logic [7:0] O_LAF  = 8'b0001_0011;
    localparam logic [7:0] O_FULL = 8'b0000_1001;
    localparam logic [7:0] O_LP   = 8'b0000_0011;
    localparam logic [7:0] O_CPE  = 8'b0000_0101;
    localparam logic [7:0] O_WTE  = 8'b0000_0001;

    logic [7:0] outs;
    assign outs = {detect_add, lfd_state, ld_state, laf_state,
                   full_state, rst_int_reg, write_enb_reg, busy};

    router_fsm dut (
        .clock            (clock),
        .resetn           (resetn),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .fifo_empty_0     (fifo_empty_0),
        .fifo_empty_1     (fifo_empty_1),
        .fifo_empty_2     (fifo_empty_2),
        .soft_reset_0     (soft_reset_0),
        .soft_reset_1     (soft_reset_1),
        .soft_reset_2     (soft_reset_2),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .rst_int_reg      (rst_int_reg),
        .write_enb_reg    (write_enb_reg),
        .busy             (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic step_chk(input string tag, input logic [7:0] exp);
        tick();
        check_eq(tag, outs, exp);
    endtask

    task automatic addr_chk(input string tag, input logic [1:0] exp);
        check_eq(tag, {6'd0, dut.addr_reg}, {6'd0, exp});
    endtask

    initial begin
        resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty_0 = 1'b0; fifo_empty_1 = 1'b0; fifo_empty_2 = 1'b0;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        parity_done = 1'b0; low_packet_valid = 1'b0;
        tick();
        step_chk("reset_outs", O_DA);
        addr_chk("reset_addr", 2'd0);
        resetn = 1'b1;

        // Normal packet to port 1
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty_1 = 1'b1;
        step_chk("p1_lfd", O_LFD);
        addr_chk("p1_addr", 2'd1);
        data_in = 2'd3;
        for (int i = 0; i < 3; i++) step_chk($sformatf("p1_ld%0d", i), O_LD);
        pkt_valid = 1'b0;
        step_chk("p1_lp", O_LP);
        step_chk("p1_cpe", O_CPE);
        step_chk("p1_idle", O_DA);

        // Port 2 busy: wait, other ports going empty must not release it
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1;
        step_chk("p2_wte0", O_WTE);
        addr_chk("p2_addr", 2'd2);
        data_in = 2'd0;
        for (int i = 1; i < 4; i++) step_chk($sformatf("p2_wte%0d", i), O_WTE);
        fifo_empty_2 = 1'b1;
        step_chk("p2_lfd", O_LFD);
        step_chk("p2_ld", O_LD);

        // FIFO full stall for 3 cycles, then resume via LOAD_AFTER_FULL
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) step_chk($sformatf("p2_full%0d", i), O_FULL);
        fifo_full = 1'b0;
        step_chk("p2_laf", O_LAF);
        low_packet_valid = 1'b1;
        step_chk("p2_laf_to_lp", O_LP);
        low_packet_valid = 1'b0;
        fifo_full = 1'b1;
        step_chk("p2_cpe", O_CPE);
        step_chk("p2_cpe_full", O_FULL);
        fifo_full = 1'b0;
        step_chk("p2_laf2", O_LAF);
        parity_done = 1'b1; low_packet_valid = 1'b1;
        step_chk("p2_laf_done", O_DA);
        parity_done = 1'b0; low_packet_valid = 1'b0;

        // Dropped headers: invalid address, and pkt_valid low
        pkt_valid = 1'b1; data_in = 2'd3;
        step_chk("bad_addr", O_DA);
        addr_chk("bad_addr_keep", 2'd2);
        pkt_valid = 1'b0; data_in = 2'd1;
        step_chk("no_valid", O_DA);
        addr_chk("no_valid_keep", 2'd2);

        // Port 0: full beats end-of-payload, LAF back to LD, soft resets
        pkt_valid = 1'b1; data_in = 2'd0; fifo_empty_0 = 1'b1;
        step_chk("p0_lfd", O_LFD);
        step_chk("p0_ld", O_LD);
        pkt_valid = 1'b0; fifo_full = 1'b1;
        step_chk("p0_full_wins", O_FULL);
        pkt_valid = 1'b1; fifo_full = 1'b0;
        step_chk("p0_laf", O_LAF);
        step_chk("p0_laf_to_ld", O_LD);
        soft_reset_1 = 1'b1; soft_reset_2 = 1'b1;
        step_chk("p0_other_soft", O_LD);
        soft_reset_1 = 1'b0; soft_reset_2 = 1'b0; soft_reset_0 = 1'b1;
        step_chk("p0_soft", O_DA);
        soft_reset_0 = 1'b0;

        // Soft reset out of WAIT_TILL_EMPTY
        data_in = 2'd2; fifo_empty_2 = 1'b0;
        step_chk("p2b_wte", O_WTE);
        soft_reset_2 = 1'b1; fifo_empty_2 = 1'b1;
        step_chk("p2b_soft", O_DA);
        soft_reset_2 = 1'b0;

        // Hard reset mid-packet
        data_in = 2'd1; fifo_empty_1 = 1'b1;
        step_chk("p1b_lfd", O_LFD);
        step_chk("p1b_ld", O_LD);
        resetn = 1'b0; soft_reset_1 = 1'b1; fifo_full = 1'b1;
        step_chk("p1b_rst", O_DA);
        addr_chk("p1b_rst_addr", 2'd0);
        resetn = 1'b1; soft_reset_1 = 1'b0; fifo_full = 1'b0; pkt_valid = 1'b0;
        step_chk("post_rst_idle", O_DA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
